// File: rtl/aximm_csr_test_seq.sv
// Autonomous AVMM CSR master that runs the AXI-MM loopback test on aximm_aib_top and reports pass/fail.
// Optional build macro AXIMM_SEQ_CAPTURE_EN adds the capture reads and the o_din_first/o_din_last ports.
module aximm_csr_test_seq #(
  parameter logic [31:0] DLY_X       = 32'h0000000C,
  parameter logic [31:0] DLY_Y       = 32'h00000020,
  parameter logic [31:0] DLY_Z       = 32'h00001770,
  parameter logic [31:0] XFER_ADDR   = 32'h10000000,
  parameter logic [31:0] BURST_CFG   = 32'h00041804,
  parameter int unsigned POLL_GAP    = 16,
  parameter logic [31:0] TIMEOUT_CYC = 32'd2000000
) (
  input  logic        avmm_clk,
  input  logic        avmm_rst_n,
  input  logic        i_start,
  output logic [31:0] o_wr_addr,
  output logic [31:0] o_wrdata,
  output logic        o_wren,
  output logic        o_rden,
  input  logic        i_master_waitrequest,
  input  logic        i_master_readdatavalid,
  input  logic [31:0] i_master_readdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_pass,
  output logic        o_fail,
  output logic        o_timeout,
  output logic [3:0]  o_state
`ifdef AXIMM_SEQ_CAPTURE_EN
  ,
  output logic [63:0] o_din_first,
  output logic [63:0] o_din_last
`endif
);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_WR_DX      = 4'd1,
    S_WR_DY      = 4'd2,
    S_WR_DZ      = 4'd3,
    S_POLL_LINK  = 4'd4,
    S_WR_WADDR   = 4'd5,
    S_WR_WCFG    = 4'd6,
    S_POLL_WDONE = 4'd7,
    S_WR_RADDR   = 4'd8,
    S_WR_RCFG    = 4'd9,
    S_POLL_RDONE = 4'd10,
    S_CAPTURE    = 4'd11,
    S_RD_STS     = 4'd12,
    S_DONE       = 4'd13
  } state_e;

  // Each CSR state runs one transaction through these phases.
  typedef enum logic [1:0] {
    PH_NONE  = 2'd0,
    PH_REQ   = 2'd1,
    PH_RDATA = 2'd2,
    PH_GAP   = 2'd3
  } phase_e;

  state_e      state_q, state_d, succ;
  phase_e      phase_q, phase_d;
  logic [15:0] gap_q, gap_d;
  logic [31:0] cnt_q, cnt_d;
  logic        done_q, done_d, pass_q, pass_d, fail_q, fail_d, tmo_q, tmo_d;
  logic [31:0] req_addr, req_data;
  logic        req_rd, poll_ok, tmo_hit;
  logic        unused_rd_bits;
`ifdef AXIMM_SEQ_CAPTURE_EN
  logic [1:0]  cap_q, cap_d;
  logic [63:0] din_first_q, din_first_d, din_last_q, din_last_d;
`endif

  // Per-state CSR address, write data, direction and successor.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    req_addr = '0;
    req_data = '0;
    req_rd   = 1'b0;
    succ     = state_q;
    case (state_q)
      S_WR_DX:      begin req_addr = 32'h5000_2000; req_data = DLY_X;     succ = S_WR_DY;      end
      S_WR_DY:      begin req_addr = 32'h5000_2004; req_data = DLY_Y;     succ = S_WR_DZ;      end
      S_WR_DZ:      begin req_addr = 32'h5000_2008; req_data = DLY_Z;     succ = S_POLL_LINK;  end
      S_POLL_LINK:  begin req_addr = 32'h5000_100C; req_rd = 1'b1;        succ = S_WR_WADDR;   end
      S_WR_WADDR:   begin req_addr = 32'h5000_1004; req_data = XFER_ADDR; succ = S_WR_WCFG;    end
      S_WR_WCFG:    begin req_addr = 32'h5000_1000; req_data = BURST_CFG; succ = S_POLL_WDONE; end
      S_POLL_WDONE: begin req_addr = 32'h5000_1008; req_rd = 1'b1;        succ = S_WR_RADDR;   end
      S_WR_RADDR:   begin req_addr = 32'h5000_1004; req_data = XFER_ADDR; succ = S_WR_RCFG;    end
      S_WR_RCFG:    begin req_addr = 32'h5000_1010; req_data = BURST_CFG; succ = S_POLL_RDONE; end
`ifdef AXIMM_SEQ_CAPTURE_EN
      S_POLL_RDONE: begin req_addr = 32'h5000_1008; req_rd = 1'b1;        succ = S_CAPTURE;    end
      // 0x...20, 24, 30, 34: index bit 1 selects the 0x10 block, bit 0 the upper word.
      S_CAPTURE:    begin
        req_addr = {24'h500040, 2'b00, 1'b1, cap_q[1], 1'b0, cap_q[0], 2'b00};
        req_rd   = 1'b1;
        succ     = S_RD_STS;
      end
`else
      S_POLL_RDONE: begin req_addr = 32'h5000_1008; req_rd = 1'b1;        succ = S_RD_STS;     end
`endif
      S_RD_STS:     begin req_addr = 32'h5000_1008; req_rd = 1'b1;        succ = S_DONE;       end
      default:      ;
    endcase
  end

  always_comb begin
    case (state_q)
      S_POLL_LINK:  poll_ok = (i_master_readdata[3:0] == 4'hF);
      S_POLL_WDONE: poll_ok = i_master_readdata[4];
      S_POLL_RDONE: poll_ok = i_master_readdata[5];
      default:      poll_ok = 1'b1;
    endcase
  end

  assign tmo_hit        = (TIMEOUT_CYC != 32'd0) && (cnt_q == TIMEOUT_CYC);
  assign unused_rd_bits = ^i_master_readdata[31:6];

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    tmo_d   = tmo_q;
`ifdef AXIMM_SEQ_CAPTURE_EN
    cap_d       = cap_q;
    din_first_d = din_first_q;
    din_last_d  = din_last_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_d = S_WR_DX;
          phase_d = PH_REQ;
          gap_d   = '0;
          cnt_d   = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          tmo_d   = 1'b0;
`ifdef AXIMM_SEQ_CAPTURE_EN
          cap_d   = '0;
`endif
        end
      end
      default: begin
        if (cnt_q != TIMEOUT_CYC) cnt_d = cnt_q + 32'd1;
        // A stalled request must still finish its handshake; any read data that follows is dropped.
        if (tmo_hit && !(phase_q == PH_REQ && i_master_waitrequest)) begin
          state_d = S_DONE;
          phase_d = PH_NONE;
          done_d  = 1'b1;
          pass_d  = 1'b0;
          fail_d  = 1'b1;
          tmo_d   = 1'b1;
        end else begin
          case (phase_q)
            PH_REQ: begin
              if (!i_master_waitrequest) begin
                if (req_rd) begin
                  phase_d = PH_RDATA;
                end else begin
                  state_d = succ;
                  phase_d = PH_GAP;
                  gap_d   = 16'd1;
                end
              end
            end
            PH_RDATA: begin
              if (i_master_readdatavalid) begin
                if (state_q == S_RD_STS) begin
                  state_d = S_DONE;
                  phase_d = PH_NONE;
                  done_d  = 1'b1;
                  pass_d  = (i_master_readdata[3:0] == 4'hF);
                  fail_d  = (i_master_readdata[3:0] != 4'hF);
                end else if (poll_ok) begin
                  state_d = succ;
                  phase_d = PH_GAP;
                  gap_d   = 16'd1;
`ifdef AXIMM_SEQ_CAPTURE_EN
                  if (state_q == S_CAPTURE) begin
                    case (cap_q)
                      2'd0:    din_first_d[31:0]  = i_master_readdata;
                      2'd1:    din_first_d[63:32] = i_master_readdata;
                      2'd2:    din_last_d[31:0]   = i_master_readdata;
                      default: din_last_d[63:32]  = i_master_readdata;
                    endcase
                    if (cap_q != 2'd3) state_d = S_CAPTURE;
                    cap_d = cap_q + 2'd1;
                  end
`endif
                end else begin
                  phase_d = PH_GAP;
                  gap_d   = 16'(POLL_GAP);
                end
              end
            end
            PH_GAP: begin
              if (gap_q <= 16'd1) phase_d = PH_REQ;
              else                gap_d   = gap_q - 16'd1;
            end
            default: phase_d = PH_REQ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge avmm_clk or negedge avmm_rst_n) begin
    if (!avmm_rst_n) begin
      state_q <= S_IDLE;
      phase_q <= PH_NONE;
      gap_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      tmo_q   <= 1'b0;
`ifdef AXIMM_SEQ_CAPTURE_EN
      cap_q       <= '0;
      din_first_q <= '0;
      din_last_q  <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of every other flop.
      state_q <= state_d;
      phase_q <= phase_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      tmo_q   <= tmo_d;
`ifdef AXIMM_SEQ_CAPTURE_EN
      cap_q       <= cap_d;
      din_first_q <= din_first_d;
      din_last_q  <= din_last_d;
`endif
    end
  end

  // Requests decode straight from flops, so reset drops them without waiting for a clock.
  assign o_wren    = (phase_q == PH_REQ) && !req_rd;
  assign o_rden    = (phase_q == PH_REQ) && req_rd;
  assign o_wr_addr = (phase_q == PH_REQ) ? req_addr : 32'd0;
  assign o_wrdata  = (phase_q == PH_REQ) ? req_data : 32'd0;
  assign o_busy    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign o_done    = done_q;
  assign o_pass    = pass_q;
  assign o_fail    = fail_q;
  assign o_timeout = tmo_q;
  assign o_state   = state_q;
`ifdef AXIMM_SEQ_CAPTURE_EN
  assign o_din_first = din_first_q;
  assign o_din_last  = din_last_q;
`endif

endmodule

// File: tb/tb_aximm_csr_test_seq.sv
// Directed bench for aximm_csr_test_seq: a CSR slave model answers requests and a scoreboard checks every accepted transaction.
module tb_aximm_csr_test_seq;

  localparam logic [31:0] DLY_X     = 32'h0000000C;
  localparam logic [31:0] DLY_Y     = 32'h00000020;
  localparam logic [31:0] DLY_Z     = 32'h00001770;
  localparam logic [31:0] XFER_ADDR = 32'h10000000;
  localparam logic [31:0] BURST_CFG = 32'h00041804;
  localparam int          POLL_GAP  = 16;
  localparam logic [31:0] LINK_A    = 32'h5000_100C;
  localparam logic [31:0] STS_A     = 32'h5000_1008;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic        clk, rst_n, i_start;
  logic [31:0] o_wr_addr, o_wrdata, rdata;
  logic        o_wren, o_rden, waitreq, rdvalid;
  logic        o_busy, o_done, o_pass, o_fail, o_timeout;
  logic [3:0]  o_state;
`ifdef AXIMM_SEQ_CAPTURE_EN
  logic [63:0] o_din_first, o_din_last;
`endif

  int   tests_run = 0;
  int   fail_cnt  = 0;
  int   cyc       = 0;
  txn_t expq[$];

  // Slave behaviour knobs, set by the directed steps.
  int         wait_cycles = 0;
  int         link_bad    = 0;
  logic       link_never  = 1'b0;
  logic [3:0] final_sts   = 4'hF;

  int          req_age, link_polls, last_link_cyc;
  logic        have_link, acc_prev, hold_we, hold_rd;
  logic [31:0] hold_addr, hold_data;

  aximm_csr_test_seq #(
    .DLY_X(DLY_X), .DLY_Y(DLY_Y), .DLY_Z(DLY_Z), .XFER_ADDR(XFER_ADDR),
    .BURST_CFG(BURST_CFG), .POLL_GAP(POLL_GAP), .TIMEOUT_CYC(32'd500)
  ) dut (
    .avmm_clk(clk), .avmm_rst_n(rst_n), .i_start(i_start),
    .o_wr_addr(o_wr_addr), .o_wrdata(o_wrdata), .o_wren(o_wren), .o_rden(o_rden),
    .i_master_waitrequest(waitreq), .i_master_readdatavalid(rdvalid),
    .i_master_readdata(rdata),
    .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_fail(o_fail),
    .o_timeout(o_timeout), .o_state(o_state)
`ifdef AXIMM_SEQ_CAPTURE_EN
    , .o_din_first(o_din_first), .o_din_last(o_din_last)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_txn(input logic we, input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.data = d;
    expq.push_back(t);
  endtask

  task automatic push_seq(input int n_link);
    push_txn(1'b1, 32'h5000_2000, DLY_X);
    push_txn(1'b1, 32'h5000_2004, DLY_Y);
    push_txn(1'b1, 32'h5000_2008, DLY_Z);
    for (int i = 0; i < n_link; i++) push_txn(1'b0, LINK_A, 32'd0);
    push_txn(1'b1, 32'h5000_1004, XFER_ADDR);
    push_txn(1'b1, 32'h5000_1000, BURST_CFG);
    push_txn(1'b0, STS_A, 32'd0);
    push_txn(1'b1, 32'h5000_1004, XFER_ADDR);
    push_txn(1'b1, 32'h5000_1010, BURST_CFG);
    push_txn(1'b0, STS_A, 32'd0);
`ifdef AXIMM_SEQ_CAPTURE_EN
    push_txn(1'b0, 32'h5000_4020, 32'd0);
    push_txn(1'b0, 32'h5000_4024, 32'd0);
    push_txn(1'b0, 32'h5000_4030, 32'd0);
    push_txn(1'b0, 32'h5000_4034, 32'd0);
`endif
    push_txn(1'b0, STS_A, 32'd0);
  endtask

  // Called at each accepted request: pop the expected transaction and compare.
  task automatic score();
    txn_t e;
    if (expq.size() != 0) begin
      e = expq.pop_front();
    end else if (link_never) begin
      e.we = 1'b0; e.addr = LINK_A; e.data = 32'd0;
    end else begin
      check("sb_unexpected", {95'd0, o_wren, o_wr_addr}, {128{1'b1}});
      return;
    end
    check("txn_we", o_wren, e.we);
    check("txn_addr", o_wr_addr, e.addr);
    if (e.we) check("txn_data", o_wrdata, e.data);
  endtask

  function automatic logic [31:0] resp_val(input logic [31:0] a, input int polls);
    case (a)
      LINK_A:        resp_val = (link_never || polls < link_bad) ? 32'h7 : 32'hF;
      STS_A:         resp_val = {26'd0, 2'b11, final_sts};
      32'h5000_4020: resp_val = 32'h11111111;
      32'h5000_4024: resp_val = 32'h22222222;
      32'h5000_4030: resp_val = 32'h33333333;
      32'h5000_4034: resp_val = 32'h44444444;
      default:       resp_val = 32'd0;
    endcase
  endfunction

  assign waitreq = (o_wren || o_rden) && (req_age < wait_cycles);

  // CSR slave model: stalls each request wait_cycles cycles, returns read data one cycle after acceptance.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_age   <= 0;
      rdvalid   <= 1'b0;
      rdata     <= '0;
      acc_prev  <= 1'b0;
      have_link <= 1'b0;
      link_polls <= 0;
    end else begin
      rdvalid  <= 1'b0;
      acc_prev <= 1'b0;
      if (i_start) begin
        link_polls <= 0;
        have_link  <= 1'b0;
      end
      if (acc_prev) check("idle_gap", o_wren || o_rden, 1'b0);
      if ((o_wren || o_rden) && req_age != 0)
        check("req_stable", {o_wren, o_rden, o_wr_addr, o_wrdata}, {hold_we, hold_rd, hold_addr, hold_data});
      if (o_wren || o_rden) begin
        hold_we   <= o_wren;
        hold_rd   <= o_rden;
        hold_addr <= o_wr_addr;
        hold_data <= o_wrdata;
        if (waitreq) begin
          req_age <= req_age + 1;
        end else begin
          req_age  <= 0;
          acc_prev <= 1'b1;
          score();
          if (o_rden) begin
            rdvalid <= 1'b1;
            rdata   <= resp_val(o_wr_addr, link_polls);
            if (o_wr_addr == LINK_A) begin
              link_polls <= link_polls + 1;
              if (have_link) check("poll_spacing", (cyc - last_link_cyc) >= POLL_GAP + 1, 1'b1);
              have_link     <= 1'b1;
              last_link_cyc <= cyc;
            end
          end
        end
      end
    end
  end

  task automatic start_run();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check("start_wren", o_wren, 1'b1);
    check("start_flags", {o_busy, o_done, o_timeout, o_fail}, 4'b1000);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000 && !o_done; i++) @(negedge clk);
    check("done_reached", o_done, 1'b1);
  endtask

  task automatic check_result(input string tag, input logic pass, input logic tmo);
    check(tag, {o_busy, o_done, o_pass, o_fail, o_timeout}, {1'b0, 1'b1, pass, !pass, tmo});
    check("sb_empty", expq.size(), 0);
  endtask

  initial begin
    int t0;
    rst_n   = 1'b0;
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {o_wren, o_rden, o_busy, o_done, o_pass, o_fail, o_timeout, o_state, o_wr_addr, o_wrdata}, '0);
`ifdef AXIMM_SEQ_CAPTURE_EN
    check("reset_din", {o_din_first, o_din_last}, '0);
`endif
    rst_n = 1'b1;

    // Zero-wait slave, everything ready on first poll.
    push_seq(1);
    start_run();
    wait_done();
    check_result("t1_result", 1'b1, 1'b0);
`ifdef AXIMM_SEQ_CAPTURE_EN
    check("din_first", o_din_first, 64'h2222222211111111);
    check("din_last", o_din_last, 64'h4444444433333333);
`endif

    // Every request stalled for 5 cycles.
    wait_cycles = 5;
    push_seq(1);
    start_run();
    wait_done();
    check_result("t2_result", 1'b1, 1'b0);
    wait_cycles = 0;

    // Link reports 4'h7 for three polls before coming up.
    link_bad = 3;
    push_seq(4);
    start_run();
    wait_done();
    check_result("t3_result", 1'b1, 1'b0);
    link_bad = 0;

    // Final status mismatch.
    final_sts = 4'hE;
    push_seq(1);
    start_run();
    wait_done();
    check_result("t4_result", 1'b0, 1'b0);
    final_sts = 4'hF;

    // Link never comes up: timeout near cycle 500, then restart.
    link_never = 1'b1;
    push_txn(1'b1, 32'h5000_2000, DLY_X);
    push_txn(1'b1, 32'h5000_2004, DLY_Y);
    push_txn(1'b1, 32'h5000_2008, DLY_Z);
    push_txn(1'b0, LINK_A, 32'd0);
    start_run();
    t0 = cyc;
    wait_done();
    check("t5_tmo_time", (cyc - t0 >= 495) && (cyc - t0 <= 520), 1'b1);
    check_result("t5_result", 1'b0, 1'b1);
    link_never = 1'b0;
    push_seq(1);
    start_run();
    wait_done();
    check_result("t5_restart", 1'b1, 1'b0);

    // Reset while the write-done poll is stalled on the bus.
    wait_cycles = 5;
    push_seq(1);
    start_run();
    for (int i = 0; i < 2000 && !(o_rden && o_wr_addr == STS_A); i++) @(negedge clk);
    check("t6_in_wdone", {o_rden, o_wr_addr}, {1'b1, STS_A});
    #2 rst_n = 1'b0;
    #1 check("t6_reset_outputs", {o_wren, o_rden, o_busy, o_done, o_pass, o_fail, o_timeout, o_state, o_wr_addr, o_wrdata}, '0);
    expq.delete();
    wait_cycles = 0;
    @(negedge clk);
    rst_n = 1'b1;
    push_seq(1);
    start_run();
    wait_done();
    check_result("t6_restart", 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, observed still running, required finished");
    $fatal(1, "watchdog");
  end

endmodule
